// File: rtl/battleship_turn_ctrl.sv
// Multi-player turn sequencer for the battleship game: rotation over live fleets,
// shot budget, idle timeout, saturating hit scoring and winner selection.
module battleship_turn_ctrl #(
  parameter int NUM_PLAYERS    = 2,
  parameter int MAX_TURNS      = 20,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int HIT_W          = 4,
  localparam int PW  = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int TW  = ($clog2(MAX_TURNS + 1) > 1) ? $clog2(MAX_TURNS + 1) : 1,
  localparam int TMW = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start_btn,
  input  logic                         reset_btn,
  input  logic                         shot_select,
  input  logic                         hit,
  input  logic [NUM_PLAYERS-1:0]       fleet_sunk,
  output logic [5:0]                   current_state,
  output logic [PW-1:0]                active_player,
  output logic [TW-1:0]                turns_left,
  output logic [NUM_PLAYERS*HIT_W-1:0] hit_counts,
  output logic                         shot_ack,
  output logic                         turn_timeout,
  output logic                         restart_pulse,
  output logic [PW-1:0]                winner,
  output logic                         winner_valid
);

  typedef enum logic [5:0] {
    IDLE          = 6'b000001,
    SETUP         = 6'b000010,
    PLAYER_TURN   = 6'b000100,
    EVALUATE_SHOT = 6'b001000,
    ADVANCE       = 6'b010000,
    GAME_OVER     = 6'b100000
  } state_t;

  localparam logic [TMW-1:0] TIMER_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TMW'(TIMEOUT_CYCLES - 1);

  state_t           state, next_state;
  logic [HIT_W-1:0] hits [NUM_PLAYERS];
  logic [TMW-1:0]   timer;
  logic             hit_lat;

  int               alive_cnt;
  int               idx;
  logic [PW-1:0]    first_alive, next_alive, best_idx;
  logic [HIT_W-1:0] best_val;
  logic             found_first, found_next, have_best, cand;
  logic             timeout_fire, game_end;

  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + HIT_W'(1) : v;
  endfunction

  function automatic logic [TW-1:0] dec_floor(input logic [TW-1:0] v);
    return (v != '0) ? v - TW'(1) : v;
  endfunction

  assign current_state = state;

  always_comb begin
    hit_counts = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) hit_counts[i*HIT_W +: HIT_W] = hits[i];
  end

  // Fleet survey: first live player, next live player after the active one,
  // and the best scorer among candidates (everyone when all fleets are sunk).
  always_comb begin
    alive_cnt   = 0;
    idx         = 0;
    first_alive = '0;
    found_first = 1'b0;
    next_alive  = active_player;
    found_next  = 1'b0;
    best_idx    = '0;
    best_val    = '0;
    have_best   = 1'b0;
    cand        = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!fleet_sunk[i]) begin
        alive_cnt = alive_cnt + 1;
        if (!found_first) begin
          first_alive = PW'(i);
          found_first = 1'b1;
        end
      end
    end
    for (int k = 1; k < NUM_PLAYERS; k++) begin
      idx = (int'(active_player) + k) % NUM_PLAYERS;
      if (!found_next && !fleet_sunk[idx]) begin
        next_alive = PW'(idx);
        found_next = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      cand = (alive_cnt == 0) || !fleet_sunk[i];
      if (cand && (!have_best || (hits[i] > best_val))) begin
        best_idx  = PW'(i);
        best_val  = hits[i];
        have_best = 1'b1;
      end
    end
  end

  assign timeout_fire = (TIMEOUT_CYCLES != 0) && (state == PLAYER_TURN) &&
                        !reset_btn && !shot_select && (timer == TIMER_LAST);
  assign game_end     = (alive_cnt < 2) || (turns_left == '0);

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:          if (start_btn || reset_btn) next_state = SETUP;
      SETUP:         next_state = PLAYER_TURN;
      PLAYER_TURN: begin
        if (reset_btn)         next_state = IDLE;
        else if (shot_select)  next_state = EVALUATE_SHOT;
        else if (timeout_fire) next_state = ADVANCE;
      end
      EVALUATE_SHOT: next_state = reset_btn ? IDLE : ADVANCE;
      ADVANCE: begin
        if (reset_btn)     next_state = IDLE;
        else if (game_end) next_state = GAME_OVER;
        else               next_state = PLAYER_TURN;
      end
      GAME_OVER:     if (start_btn || reset_btn) next_state = IDLE;
      default:       next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      active_player <= '0;
      turns_left    <= TW'(MAX_TURNS);
      for (int i = 0; i < NUM_PLAYERS; i++) hits[i] <= '0;
      timer         <= '0;
      hit_lat       <= 1'b0;
      winner        <= '0;
      shot_ack      <= 1'b0;
      turn_timeout  <= 1'b0;
      restart_pulse <= 1'b0;
      winner_valid  <= 1'b0;
    end else begin
      state         <= next_state;
      restart_pulse <= (next_state == SETUP);
      shot_ack      <= (next_state == EVALUATE_SHOT);
      turn_timeout  <= timeout_fire;
      winner_valid  <= (next_state == GAME_OVER);
      if ((state == ADVANCE) && (next_state == GAME_OVER)) winner <= best_idx;
      case (state)
        SETUP: begin
          turns_left    <= TW'(MAX_TURNS);
          for (int i = 0; i < NUM_PLAYERS; i++) hits[i] <= '0;
          active_player <= first_alive;
          timer         <= '0;
        end
        PLAYER_TURN: begin
          timer <= timer + TMW'(1);
          if (!reset_btn && shot_select) hit_lat <= hit;
          if (timeout_fire) turns_left <= dec_floor(turns_left);
        end
        EVALUATE_SHOT: begin
          if (!reset_btn) begin
            for (int i = 0; i < NUM_PLAYERS; i++)
              if (PW'(i) == active_player) hits[i] <= sat_inc(hits[i], hit_lat);
            turns_left <= dec_floor(turns_left);
          end
        end
        ADVANCE: begin
          if (!reset_btn && !game_end) begin
            active_player <= next_alive;
            timer         <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Bench for battleship_turn_ctrl: directed scenarios plus randomized games
// compared against a turn-level model of the game rules.
module tb_battleship_turn_ctrl;
  localparam int NP = 3;
  localparam int MT = 12;
  localparam int TO = 5;
  localparam int HW = 2;

  localparam logic [5:0] S_IDLE  = 6'b000001;
  localparam logic [5:0] S_SETUP = 6'b000010;
  localparam logic [5:0] S_PT    = 6'b000100;
  localparam logic [5:0] S_EVAL  = 6'b001000;
  localparam logic [5:0] S_ADV   = 6'b010000;
  localparam logic [5:0] S_GO    = 6'b100000;

  logic clk = 1'b0;
  logic reset_n, start_btn, reset_btn, shot_select, hit;
  logic [NP-1:0] fleet_sunk;
  logic [5:0] current_state;
  logic [1:0] active_player, winner;
  logic [3:0] turns_left;
  logic [NP*HW-1:0] hit_counts;
  logic shot_ack, turn_timeout, restart_pulse, winner_valid;

  int vectors = 0;
  int miscompares = 0;

  int m_hits [NP];
  int m_turns;
  int m_ap;

  typedef struct {
    logic h;
    int   exp_ap;
    int   exp_turns;
    logic [NP*HW-1:0] exp_hits;
  } vec_t;
  vec_t tbl [4];

  battleship_turn_ctrl #(.NUM_PLAYERS(NP), .MAX_TURNS(MT), .TIMEOUT_CYCLES(TO), .HIT_W(HW)) dut (
    .clk(clk), .reset_n(reset_n), .start_btn(start_btn), .reset_btn(reset_btn),
    .shot_select(shot_select), .hit(hit), .fleet_sunk(fleet_sunk),
    .current_state(current_state), .active_player(active_player), .turns_left(turns_left),
    .hit_counts(hit_counts), .shot_ack(shot_ack), .turn_timeout(turn_timeout),
    .restart_pulse(restart_pulse), .winner(winner), .winner_valid(winner_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int alive_count(input logic [NP-1:0] s);
    int n = 0;
    for (int i = 0; i < NP; i++) if (!s[i]) n++;
    return n;
  endfunction

  function automatic int first_live(input logic [NP-1:0] s);
    for (int i = 0; i < NP; i++) if (!s[i]) return i;
    return 0;
  endfunction

  function automatic int next_live(input int ap, input logic [NP-1:0] s);
    int p = ap;
    for (int k = 0; k < NP; k++) begin
      p = (p + 1) % NP;
      if (!s[p]) return p;
    end
    return ap;
  endfunction

  function automatic int model_winner(input logic [NP-1:0] s);
    int best = 0, bv = -1;
    int a = alive_count(s);
    for (int i = 0; i < NP; i++)
      if ((a == 0 || !s[i]) && m_hits[i] > bv) begin
        best = i;
        bv = m_hits[i];
      end
    return best;
  endfunction

  function automatic logic [NP*HW-1:0] pack_hits();
    logic [NP*HW-1:0] v = '0;
    for (int i = 0; i < NP; i++) v[i*HW +: HW] = HW'(m_hits[i]);
    return v;
  endfunction

  // From IDLE: press start, verify SETUP pulse and the freshly initialised turn.
  task automatic start_game(input logic [NP-1:0] s);
    fleet_sunk = s;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    check("setup_state", current_state, S_SETUP);
    check("restart_pulse_hi", restart_pulse, 1);
    step();
    check("turn_state", current_state, S_PT);
    check("restart_pulse_lo", restart_pulse, 0);
    check("init_turns", turns_left, MT);
    check("init_hits", hit_counts, 0);
    check("init_player", active_player, first_live(s));
    m_turns = MT;
    for (int i = 0; i < NP; i++) m_hits[i] = 0;
    m_ap = first_live(s);
  endtask

  // In PLAYER_TURN: fire one shot, end in ADVANCE.
  task automatic do_shot(input logic h);
    shot_select = 1'b1;
    hit = h;
    step();
    shot_select = 1'b0;
    hit = 1'b0;
    check("eval_state", current_state, S_EVAL);
    check("shot_ack", shot_ack, 1);
    step();
    check("adv_state", current_state, S_ADV);
    check("adv_no_ack", shot_ack, 0);
  endtask

  // In ADVANCE: predict and check the outcome of the advance step.
  task automatic finish_adv(output bit over);
    over = (alive_count(fleet_sunk) < 2) || (m_turns == 0);
    if (over) begin
      step();
      check("over_state", current_state, S_GO);
      check("winner_valid", winner_valid, 1);
      check("winner", winner, model_winner(fleet_sunk));
    end else begin
      m_ap = next_live(m_ap, fleet_sunk);
      step();
      check("next_turn_state", current_state, S_PT);
      check("next_player", active_player, m_ap);
    end
  endtask

  initial begin
    bit over;
    reset_n = 1'b0; start_btn = 1'b0; reset_btn = 1'b0;
    shot_select = 1'b0; hit = 1'b0; fleet_sunk = '0;
    step(); step();
    check("rst_state", current_state, S_IDLE);
    check("rst_player", active_player, 0);
    check("rst_turns", turns_left, MT);
    check("rst_hits", hit_counts, 0);
    check("rst_winner", winner, 0);
    check("rst_pulses", {shot_ack, turn_timeout, restart_pulse, winner_valid}, 0);
    reset_n = 1'b1;
    step();
    check("idle_hold", current_state, S_IDLE);

    // Two live players: hits 1,0,1,1, then player 1 sinks and player 0 wins.
    tbl[0] = '{1'b1, 0, 11, 6'b000001};
    tbl[1] = '{1'b0, 1, 10, 6'b000001};
    tbl[2] = '{1'b1, 0,  9, 6'b000010};
    tbl[3] = '{1'b1, 1,  8, 6'b000110};
    start_game(3'b100);
    for (int i = 0; i < 4; i++) begin
      check("tbl_player", active_player, tbl[i].exp_ap);
      do_shot(tbl[i].h);
      check("tbl_turns", turns_left, tbl[i].exp_turns);
      check("tbl_hits", hit_counts, tbl[i].exp_hits);
      step();
      check("tbl_back_to_turn", current_state, S_PT);
    end
    fleet_sunk = 3'b110;
    do_shot(1'b0);
    step();
    check("sunk_over_state", current_state, S_GO);
    check("sunk_winner", winner, 0);
    check("sunk_winner_valid", winner_valid, 1);
    check("sunk_turns", turns_left, 7);
    start_btn = 1'b1; step(); start_btn = 1'b0;
    check("go_to_idle", current_state, S_IDLE);
    check("go_valid_clear", winner_valid, 0);

    // Player 1 sunk from the start: order 0,2,0,2; then abort with reset+shot.
    start_game(3'b010);
    for (int i = 0; i < 4; i++) begin
      check("skip_order", active_player, (i % 2) ? 2 : 0);
      do_shot(1'b1);
      step();
    end
    reset_btn = 1'b1; shot_select = 1'b1; hit = 1'b1;
    step();
    reset_btn = 1'b0; shot_select = 1'b0; hit = 1'b0;
    check("abort_state", current_state, S_IDLE);
    check("abort_no_ack", shot_ack, 0);
    check("abort_hits_hold", hit_counts, 6'b100010);
    check("abort_turns_hold", turns_left, 8);
    start_game(3'b010);

    // Idle turns time out after TO cycles; a shot on the timeout cycle wins.
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < TO - 1; c++) step();
      check("to_still_turn", current_state, S_PT);
      check("to_not_yet", turn_timeout, 0);
      step();
      check("to_adv_state", current_state, S_ADV);
      check("to_pulse", turn_timeout, 1);
      check("to_turns", turns_left, MT - 1 - k);
      step();
      check("to_pulse_clear", turn_timeout, 0);
      check("to_player", active_player, (k % 2) ? 0 : 2);
    end
    for (int c = 0; c < TO - 1; c++) step();
    shot_select = 1'b1; hit = 1'b0;
    step();
    shot_select = 1'b0;
    check("to_shot_eval", current_state, S_EVAL);
    check("to_shot_ack", shot_ack, 1);
    check("to_shot_no_to", turn_timeout, 0);
    step();
    check("to_shot_adv_no_to", turn_timeout, 0);
    check("to_shot_turns", turns_left, 8);
    step();
    reset_btn = 1'b1; step(); reset_btn = 1'b0;
    check("to_abort_idle", current_state, S_IDLE);

    // Saturation at 3, tie 3-3 goes to player 0, game ends on an empty budget.
    start_game(3'b100);
    for (int i = 0; i < MT; i++) begin
      do_shot(i < 10);
      step();
    end
    check("sat_hits", hit_counts, 6'b001111);
    check("sat_turns", turns_left, 0);
    check("sat_state", current_state, S_GO);
    check("sat_tie_winner", winner, 0);
    check("sat_valid", winner_valid, 1);
    reset_btn = 1'b1; step(); reset_btn = 1'b0;
    check("sat_idle", current_state, S_IDLE);

    // Asynchronous reset in the middle of EVALUATE_SHOT.
    start_game(3'b000);
    shot_select = 1'b1; hit = 1'b1;
    step();
    shot_select = 1'b0; hit = 1'b0;
    check("ar_eval", current_state, S_EVAL);
    #2 reset_n = 1'b0;
    #1;
    check("ar_state", current_state, S_IDLE);
    check("ar_ack", shot_ack, 0);
    check("ar_turns", turns_left, MT);
    check("ar_hits", hit_counts, 0);
    check("ar_player", active_player, 0);
    check("ar_flags", {turn_timeout, restart_pulse, winner_valid, winner}, 0);
    #1 reset_n = 1'b1;
    step();

    // Randomized games against the turn-level model.
    for (int g = 0; g < 40; g++) begin
      start_game(3'($urandom_range(0, 7)));
      over = 1'b0;
      while (!over) begin
        bit do_to;
        bit chg;
        logic [NP-1:0] ns;
        do_to = ($urandom_range(0, 3) == 0);
        chg = ($urandom_range(0, 5) == 0);
        ns = 3'($urandom_range(0, 7));
        if (do_to) begin
          for (int c = 0; c < TO - 1; c++) step();
          if (chg) fleet_sunk = ns;
          step();
          m_turns--;
          check("rnd_to_state", current_state, S_ADV);
          check("rnd_to_pulse", turn_timeout, 1);
        end else begin
          int d;
          logic h;
          d = $urandom_range(0, TO - 1);
          h = 1'($urandom_range(0, 1));
          for (int c = 0; c < d; c++) step();
          check("rnd_pre_shot", current_state, S_PT);
          if (chg) fleet_sunk = ns;
          do_shot(h);
          if (h && m_hits[m_ap] < 3) m_hits[m_ap]++;
          m_turns--;
          check("rnd_to_quiet", turn_timeout, 0);
        end
        check("rnd_turns", turns_left, m_turns);
        check("rnd_hits", hit_counts, pack_hits());
        finish_adv(over);
      end
      start_btn = 1'b1; step(); start_btn = 1'b0;
      check("rnd_idle", current_state, S_IDLE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
